// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: decode-stage immediate controller for RV32IM.
//   Decodes the opcode of the offered instruction into imm_sel for the ID-stage
//   sign extender, then registers instruction, PC, returned immediate, imm_sel
//   and the illegal-opcode flag into an output slot for the ID/EX boundary.
//   Ports:
//     clk, reset_n                  clock, asynchronous active-low reset
//     in_valid/in_ready             IF/ID handshake; in_inst, in_pc payload
//     imm_sel (out) / imm_ext (in)  combinational loop through the sign extender
//     flush                         kills every held instruction and the offered one
//     out_valid/out_ready           ID/EX handshake
//     out_inst, out_pc, out_imm, out_imm_sel, out_illegal  registered payload
//   Build option ID_SKID_BUFFER_EN: adds a one-entry skid slot so that in_ready
//   comes straight from a register; without it in_ready = out_ready || !out_valid.
module id_imm_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic [3:0]  imm_sel,
   input  logic [31:0] imm_ext,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_imm,
   output logic [3:0]  out_imm_sel,
   output logic        out_illegal
);
   localparam logic [2:0] IMM_TYPE1 = 3'd1;
   localparam logic [2:0] IMM_TYPE2 = 3'd2;
   localparam logic [2:0] IMM_TYPE3 = 3'd3;
   localparam logic [2:0] IMM_TYPE4 = 3'd4;
   localparam logic [2:0] IMM_TYPE5 = 3'd5;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [3:0]  sel;
      logic        ill;
   } slot_t;
   logic  illegal;
   logic  accept;
   logic  drain;
   slot_t in_slot;
   slot_t out_slot;
   // RV32IM never needs zero extension, so bit3 of imm_sel is always 0.
   always_comb begin
      imm_sel = {1'b0, IMM_TYPE3};
      illegal = 1'b0;
      case (in_inst[6:0])
         7'b0110111, 7'b0010111: imm_sel = {1'b0, IMM_TYPE1};
         7'b1101111:             imm_sel = {1'b0, IMM_TYPE2};
         7'b1100011:             imm_sel = {1'b0, IMM_TYPE4};
         7'b0100011:             imm_sel = {1'b0, IMM_TYPE5};
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b0110011, 7'b0001111, 7'b1110011: imm_sel = {1'b0, IMM_TYPE3};
         default:                illegal = 1'b1;
      endcase
   end
   assign in_slot = {in_inst, in_pc, imm_ext, imm_sel, illegal};
   assign {out_inst, out_pc, out_imm, out_imm_sel, out_illegal} = out_slot;
   assign accept = in_valid && in_ready && !flush;
   assign drain  = out_valid && out_ready;
`ifdef ID_SKID_BUFFER_EN
   logic  skid_valid;
   slot_t skid_slot;
   assign in_ready = !skid_valid;
   // An accept always finds the skid slot empty; it lands in the skid slot
   // only when the output slot is occupied and not draining this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_slot   <= '0;
         skid_slot  <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (accept && out_valid && !out_ready) begin
         skid_slot  <= in_slot;
         skid_valid <= 1'b1;
      end else if (accept) begin
         out_slot  <= in_slot;
         out_valid <= 1'b1;
      end else if (drain) begin
         out_slot   <= skid_valid ? skid_slot : out_slot;
         out_valid  <= skid_valid;
         skid_valid <= 1'b0;
      end
   end
`else
   assign in_ready = out_ready || !out_valid;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_slot  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_slot  <= in_slot;
         out_valid <= 1'b1;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end
`endif
endmodule

// File: tb/tb_id_imm_ctrl.sv
// tb_id_imm_ctrl: scoreboard bench for id_imm_ctrl with a queue-based reference model.
module tb_id_imm_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic [3:0]  imm_sel;
   logic [31:0] imm_ext;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_imm;
   logic [3:0]  out_imm_sel;
   logic        out_illegal;
`ifdef ID_SKID_BUFFER_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [3:0]  sel;
      logic        ill;
   } exp_t;
   exp_t        exp_q[$];
   exp_t        pend_e;
   logic        pend_acc = 1'b0;
   logic        pend_flush = 1'b0;
   logic        mon_en = 1'b0;
   logic [3:0]  sel_tab[logic [6:0]];
   logic [6:0]  ops[11];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   id_imm_ctrl dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .imm_sel(imm_sel), .imm_ext(imm_ext),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm),
      .out_imm_sel(out_imm_sel), .out_illegal(out_illegal)
   );

   // Environment sign extender, also reused to form expected immediates.
   function automatic logic [31:0] ext(input logic [3:0] s, input logic [31:0] i);
      case (s)
         4'd1:    return {i[31:12], 12'h000};
         4'd2:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         4'd3:    return {{20{i[31]}}, i[31:20]};
         4'd4:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         4'd5:    return {{20{i[31]}}, i[31:25], i[11:7]};
         default: return 32'h0;
      endcase
   endfunction

   always_comb imm_ext = ext(imm_sel, in_inst);

   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      e.inst = inst;
      e.pc   = pc;
      e.ill  = !sel_tab.exists(inst[6:0]);
      e.sel  = e.ill ? 4'd3 : sel_tab[inst[6:0]];
      e.imm  = ext(e.sel, inst);
      return e;
   endfunction

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // One clock of stimulus; the model applies the previous edge's effects first.
   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      logic mr;
      @(posedge clk);
      #1;
      if (pend_flush) exp_q.delete();
      else if (pend_acc) exp_q.push_back(pend_e);
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      #1;
      mr = (exp_q.size() < CAP) || (CAP == 1 && ordy);
      chk("in_ready", in_ready, mr);
      pend_acc   = v && mr && !fl;
      pend_e     = model(inst, pc);
      pend_flush = fl;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("out_valid", out_valid, exp_q.size() > 0);
            if (out_valid && out_ready && !flush && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("out_inst", out_inst, e.inst);
               chk("out_pc", out_pc, e.pc);
               chk("out_imm", out_imm, e.imm);
               chk("out_imm_sel", out_imm_sel, e.sel);
               chk("out_illegal", out_illegal, e.ill);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] r;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h0F, 7'h73};
      sel_tab[7'h37] = 4'd1; sel_tab[7'h17] = 4'd1; sel_tab[7'h6F] = 4'd2;
      sel_tab[7'h67] = 4'd3; sel_tab[7'h03] = 4'd3; sel_tab[7'h13] = 4'd3;
      sel_tab[7'h63] = 4'd4; sel_tab[7'h23] = 4'd5; sel_tab[7'h33] = 4'd3;
      sel_tab[7'h0F] = 4'd3; sel_tab[7'h73] = 4'd3;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_imm_sel", out_imm_sel, 4'b0000);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post-reset in_ready", in_ready, 1'b1);
      mon_en = 1'b1;
      // back-to-back with draining output, including drain+accept on the same edge
      cycle(1, 32'hFFF00093, 32'h100, 1, 0);
      cycle(1, 32'h123450B7, 32'h104, 1, 0);
      cycle(1, 32'hFE000EE3, 32'h108, 1, 0);
      repeat (2) cycle(0, 32'h0, 32'h0, 1, 0);
      // backpressure: three offered while output is stalled
      cycle(1, 32'h00A00113, 32'h200, 0, 0);
      cycle(1, 32'h00B00193, 32'h204, 0, 0);
      cycle(1, 32'h00C00213, 32'h208, 0, 0);
      cycle(0, 32'h0, 32'h0, 0, 0);
      repeat (3) cycle(0, 32'h0, 32'h0, 1, 0);
      // illegal opcode followed by a legal one
      cycle(1, 32'h0000007F, 32'h300, 1, 0);
      cycle(1, 32'h00000013, 32'h304, 1, 0);
      repeat (2) cycle(0, 32'h0, 32'h0, 1, 0);
      // flush with slots full and an instruction offered
      cycle(1, 32'h0040006F, 32'h400, 0, 0);
      cycle(1, 32'h00112223, 32'h404, 0, 0);
      cycle(1, 32'h00000537, 32'h408, 0, 1);
      repeat (3) cycle(0, 32'h0, 32'h0, 1, 0);
      // asynchronous reset while the output slot is valid
      cycle(1, 32'hDEADB0B7, 32'h500, 0, 0);
      cycle(0, 32'h0, 32'h0, 0, 0);
      mon_en = 1'b0;
      chk("pre-reset out_valid", out_valid, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("async out_valid", out_valid, 1'b0);
      chk("async out_inst", out_inst, 32'h0);
      chk("async out_pc", out_pc, 32'h0);
      chk("async out_imm", out_imm, 32'h0);
      chk("async out_imm_sel", out_imm_sel, 4'b0000);
      chk("async out_illegal", out_illegal, 1'b0);
      exp_q.delete();
      pend_acc = 1'b0;
      pend_flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("release in_ready", in_ready, 1'b1);
      mon_en = 1'b1;
      // randomized traffic
      repeat (2000) begin
         r = $urandom;
         r[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
         cycle($urandom_range(0, 9) < 7, r, $urandom, $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0);
      end
      repeat (4) cycle(0, 32'h0, 32'h0, 1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
